dm_byte_store: RTL and testbench
================================

Name: dm_byte_store

Overview:
- Data-memory responder for the MEM stage; consumes the store byte enables and load-extension code produced at the EX/MEM boundary.
- Performs byte-, halfword- and word-granular writes into a word-organised RAM.
- Reads the addressed word and registers the extended load result into the W stage (1-cycle latency).
- Sits between the EX/MEM register and the MEM/WB write-back mux.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words; address index = addr[log2(DEPTH_WORDS)+1:2].
- BASE_ADDR, 32'h0000_0000, byte address of word 0; accesses outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) are out of range.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- PC_M  in  32  PC of the MEM-stage instruction; used only by the write log.
- addr_M  in  32  byte address (ALU result).
- wdata_M  in  32  store data, unshifted (rt value).
- ByteEn  in  4  lane write enables: 1111 word, 0011/1100 half, one-hot byte, 0000 no write.
- mem_read_M  in  1  load in MEM stage.
- Load_extOp  in  2  00 word, 01 halfword sign-ext, 10 byte sign-ext, 11 reserved (treated as word).
- rdata_W  out  32  extended load result, registered.
- rvalid_W  out  1  rdata_W holds a load result this cycle.
- bad_be_W  out  1  registered flag: illegal ByteEn pattern or out-of-range store seen last cycle.

Behaviour:
- Reset (reset==0, async): all RAM words cleared to 0; rdata_W=0; rvalid_W=0; bad_be_W=0. Reset mid-operation aborts any in-flight write; the word is left cleared.
- Write, at posedge when ByteEn!=0 and the address is in range: lane k updated iff ByteEn[k].
- Lane data:
  - 1111: wdata_M.
  - 0011/1100: {wdata_M[15:0], wdata_M[15:0]}.
  - One-hot: wdata_M[7:0] replicated to all four lanes.
- Any other non-zero ByteEn pattern: no RAM change; bad_be_W=1 next cycle.
- Out-of-range store: no RAM change; bad_be_W=1.
- Read, combinational from RAM using addr_M[..:2]; extraction by addr_M[1:0]:
  - Halfword uses lane addr_M[1]*2.
  - Byte uses lane addr_M[1:0].
  - Sign-extend to 32 bits.
- Out-of-range read returns 0.
- At posedge: rdata_W <= extracted value when mem_read_M, else 0; rvalid_W <= mem_read_M.
- Read and write asserted together (same or different address): read returns the pre-write contents; the write still commits.
- Back-to-back store then load to the same word on consecutive cycles: the load sees the new data. No bypass is required because the write commits before the next read.
- Low address bits are ignored for word access; no misalignment trap.

Optional Feature:
- Macro DM_WRITE_LOG_EN.
- Defined: every committed write emits $display("%d@%h: *%h <= %h", $time, PC_M, {addr_M[31:2],2'b00}, merged_word), where merged_word is the full post-write word. Nothing is printed for rejected writes.
- Undefined: no display code; functionality otherwise identical.

Decomposition:
- Package dm_pkg holds:
  - EXT_WORD=2'b00, EXT_HALF=2'b01, EXT_BYTE=2'b10.
  - BE_WORD, BE_HALF_LO, BE_HALF_HI, BE_NONE constants.
  - A function legal_be(be) returning 1 for the seven legal non-zero patterns.
- Sub-module load_ext: combinational word + addr[1:0] + Load_extOp -> 32-bit extended value. It is reused by any future MEM-stage consumer.

Test Plan:
- Reset: drive reset=0 mid-run after writing 32'h1234_5678 to 0x10; release, then lw 0x10 -> rdata_W=0, rvalid_W=0 during reset.
- Store word/byte: sw 0xDEADBEEF @0x20 (BE=1111), then sb wdata=0x000000AA @0x22 (BE=0100), then lw 0x20 -> rdata_W=0xDEAABEEF one cycle after mem_read_M.
- Sign extension:
  - Word @0x30 = 0x80FF7F01.
  - lb @0x31 (Load_extOp=10) -> 0xFFFFFF7F? No: byte1 is 0x7F -> 0x0000007F.
  - lb @0x32 -> 0xFFFFFFFF.
  - lh @0x32 -> 0xFFFF80FF.
  - lh @0x30 -> 0x00007F01.
- Illegal/out-of-range: BE=0101 @0x40 -> RAM unchanged, bad_be_W=1 next cycle; sw to BASE_ADDR+4*DEPTH_WORDS -> no write, bad_be_W=1; lw there -> rdata_W=0.
- Same-cycle read+write: word 0x50=0x11111111; sw 0x22222222 @0x50 with mem_read_M=1 -> rdata_W=0x11111111; next-cycle lw 0x50 -> 0x22222222.
- DM_WRITE_LOG_EN: sh 0xBEEF @0x62 with PC_M=0x3004 on cleared RAM -> exactly one line "...@00003004: *00000060 <= beef0000"; none for the rejected BE=0110 write.

Source files
------------

// File: rtl/dm_byte_store_pkg.sv
// ============================================================================
// Module : dm_pkg
// Brief  : Shared constants and helpers for the MEM-stage byte-store RAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dm_pkg;

   localparam logic [1:0] EXT_WORD = 2'b00;
   localparam logic [1:0] EXT_HALF = 2'b01;
   localparam logic [1:0] EXT_BYTE = 2'b10;

   localparam logic [3:0] BE_WORD    = 4'b1111;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_NONE    = 4'b0000;

   typedef enum logic [2:0] {
      BC_NONE    = 3'd0,
      BC_BYTE    = 3'd1,
      BC_HALF    = 3'd2,
      BC_WORD    = 3'd3,
      BC_ILLEGAL = 3'd4
   } be_class_e;

   function automatic be_class_e be_class(input logic [3:0] be);
      case (be)
         BE_NONE:                    return BC_NONE;
         BE_WORD:                    return BC_WORD;
         BE_HALF_LO, BE_HALF_HI:     return BC_HALF;
         4'b0001, 4'b0010,
         4'b0100, 4'b1000:           return BC_BYTE;
         default:                    return BC_ILLEGAL;
      endcase
   endfunction

   function automatic logic legal_be(input logic [3:0] be);
      be_class_e c;
      c = be_class(be);
      return (c == BC_BYTE) || (c == BC_HALF) || (c == BC_WORD);
   endfunction

   // Store data is unshifted, so narrow stores replicate into every lane
   // and the byte enables pick the lanes that actually change.
   function automatic logic [31:0] lane_data(input logic [3:0] be, input logic [31:0] wdata);
      case (be_class(be))
         BC_WORD: return wdata;
         BC_HALF: return {2{wdata[15:0]}};
         default: return {4{wdata[7:0]}};
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/dm_byte_store_if.sv
// ============================================================================
// Module : dm_byte_store_if
// Brief  : EX/MEM request and MEM/WB response bundle of the data memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dm_byte_store_if;
   logic [31:0] PC_M;
   logic [31:0] addr_M;
   logic [31:0] wdata_M;
   logic [3:0]  ByteEn;
   logic        mem_read_M;
   logic [1:0]  Load_extOp;
   logic [31:0] rdata_W;
   logic        rvalid_W;
   logic        bad_be_W;

   modport master (
      output PC_M, addr_M, wdata_M, ByteEn, mem_read_M, Load_extOp,
      input  rdata_W, rvalid_W, bad_be_W
   );

   modport slave (
      input  PC_M, addr_M, wdata_M, ByteEn, mem_read_M, Load_extOp,
      output rdata_W, rvalid_W, bad_be_W
   );
endinterface

`default_nettype wire

// File: rtl/dm_byte_store_load_ext.sv
// ============================================================================
// Module : load_ext
// Brief  : Selects and sign-extends the addressed byte/halfword of a word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module load_ext
   import dm_pkg::*;
(
   input  wire logic [31:0] i_word,
   input  wire logic [1:0]  i_addr_lo,
   input  wire logic [1:0]  i_ext_op,
   output logic      [31:0] o_data
);

   logic [15:0] w_half;
   logic [7:0]  w_byte;

   always_comb begin
      w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
      w_byte = 8'h00;
      case (i_addr_lo)
         2'd0:    w_byte = i_word[7:0];
         2'd1:    w_byte = i_word[15:8];
         2'd2:    w_byte = i_word[23:16];
         default: w_byte = i_word[31:24];
      endcase
   end

   // The reserved encoding falls through to a plain word load.
   always_comb begin
      o_data = i_word;
      case (i_ext_op)
         EXT_HALF: o_data = {{16{w_half[15]}}, w_half};
         EXT_BYTE: o_data = {{24{w_byte[7]}}, w_byte};
         default:  o_data = i_word;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/dm_byte_store.sv
// ============================================================================
// Module : dm_byte_store
// Brief  : MEM-stage data RAM with lane-granular stores and registered loads.
//          Optional write trace enabled by defining DM_WRITE_LOG_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dm_byte_store
   import dm_pkg::*;
#(
   parameter int          DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
)
(
   input  wire logic       clk,
   input  wire logic       reset,
   dm_byte_store_if.slave  bus
);

   localparam int          c_IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] c_SPAN  = 33'(DEPTH_WORDS) << 2;

   logic [31:0]        r_mem [DEPTH_WORDS];
   logic [31:0]        r_rdata;
   logic               r_rvalid;
   logic               r_bad_be;

   logic [32:0]        w_offset;
   logic               w_in_range;
   logic [c_IDX_W-1:0] w_idx;
   logic [31:0]        w_rd_word;
   logic [31:0]        w_ext;
   logic               w_be_legal;
   logic               w_do_write;
   logic               w_bad;
   logic [31:0]        w_lane;
   logic [31:0]        w_merged;

   // Below-base addresses wrap to a huge 33-bit offset, so one compare covers both ends.
   assign w_offset   = {1'b0, bus.addr_M} - {1'b0, BASE_ADDR};
   assign w_in_range = (w_offset < c_SPAN);
   assign w_idx      = w_offset[c_IDX_W+1:2];
   assign w_rd_word  = w_in_range ? r_mem[w_idx] : 32'h0;

   assign w_be_legal = legal_be(bus.ByteEn);
   assign w_do_write = w_be_legal && w_in_range;
   assign w_bad      = (bus.ByteEn != BE_NONE) && (!w_be_legal || !w_in_range);
   assign w_lane     = lane_data(bus.ByteEn, bus.wdata_M);

   generate
      for (genvar k = 0; k < 4; k++) begin : g_lane
         assign w_merged[8*k +: 8] = bus.ByteEn[k] ? w_lane[8*k +: 8] : w_rd_word[8*k +: 8];
      end
   endgenerate

   load_ext u_load_ext (
      .i_word    (w_rd_word),
      .i_addr_lo (bus.addr_M[1:0]),
      .i_ext_op  (bus.Load_extOp),
      .o_data    (w_ext)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            r_mem[i] <= 32'h0;
         end
      end else if (w_do_write) begin
         r_mem[w_idx] <= w_merged;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rdata  <= 32'h0;
         r_rvalid <= 1'b0;
         r_bad_be <= 1'b0;
      end else begin
         r_rdata  <= bus.mem_read_M ? w_ext : 32'h0;
         r_rvalid <= bus.mem_read_M;
         r_bad_be <= w_bad;
      end
   end

   assign bus.rdata_W  = r_rdata;
   assign bus.rvalid_W = r_rvalid;
   assign bus.bad_be_W = r_bad_be;

`ifdef DM_WRITE_LOG_EN
   always @(posedge clk) begin
      if (reset && w_do_write) begin
         $display("%d@%h: *%h <= %h", $time, bus.PC_M, {bus.addr_M[31:2], 2'b00}, w_merged);
      end
   end
`else
   logic w_unused_pc;
   assign w_unused_pc = ^bus.PC_M;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dm_byte_store.sv
// ============================================================================
// Module : tb_dm_byte_store
// Brief  : Directed bench with a byte-level reference model for dm_byte_store.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dm_byte_store;
   import dm_pkg::*;

   localparam int          DEPTH = 4096;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   dm_byte_store_if bus ();

   dm_byte_store #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   bit check_en = 1'b0;

   logic [31:0] model_mem [DEPTH];
   logic [31:0] exp_rdata  = 32'h0;
   logic        exp_rvalid = 1'b0;
   logic        exp_bad    = 1'b0;

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
      end
   endtask

   function automatic bit model_in_range(input logic [31:0] a);
      longint diff;
      diff = longint'({32'h0, a}) - longint'({32'h0, BASE});
      return (diff >= 0) && (diff < 4 * DEPTH);
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] a, input logic [1:0] op);
      logic [15:0] h;
      logic [7:0]  b;
      h = 16'(word >> (16 * a[1]));
      b = 8'(word >> (8 * a));
      if (op == 2'b01) return 32'($signed(h));
      if (op == 2'b10) return 32'($signed(b));
      return word;
   endfunction

   function automatic bit model_legal(input logic [3:0] be);
      return (be == 4'hF) || (be == 4'h3) || (be == 4'hC) || ($countones(be) == 1);
   endfunction

   // Reference: memory as bytes per word; a narrow store drives lane k from
   // wdata byte (k mod width), reads see the contents from before this edge.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) model_mem[i] <= 32'h0;
         exp_rdata  <= 32'h0;
         exp_rvalid <= 1'b0;
         exp_bad    <= 1'b0;
      end else begin
         automatic bit          inr  = model_in_range(bus.addr_M);
         automatic int          idx  = int'((bus.addr_M - BASE) >> 2) % DEPTH;
         automatic logic [31:0] word = inr ? model_mem[idx] : 32'h0;
         automatic int          width;
         exp_rvalid <= bus.mem_read_M;
         exp_rdata  <= bus.mem_read_M ? model_load(word, bus.addr_M[1:0], bus.Load_extOp) : 32'h0;
         exp_bad    <= (bus.ByteEn != 4'h0) && (!model_legal(bus.ByteEn) || !inr);
         width = (bus.ByteEn == 4'hF) ? 4 : ($countones(bus.ByteEn) == 2 ? 2 : 1);
         if (bus.ByteEn != 4'h0 && model_legal(bus.ByteEn) && inr) begin
            for (int k = 0; k < 4; k++) begin
               if (bus.ByteEn[k]) model_mem[idx][8*k +: 8] <= bus.wdata_M[8*(k % width) +: 8];
            end
         end
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         cmp("model rdata_W",  bus.rdata_W,         exp_rdata);
         cmp("model rvalid_W", {31'h0, bus.rvalid_W}, {31'h0, exp_rvalid});
         cmp("model bad_be_W", {31'h0, bus.bad_be_W}, {31'h0, exp_bad});
      end
   end

   task automatic idle();
      bus.ByteEn     = 4'h0;
      bus.mem_read_M = 1'b0;
      bus.Load_extOp = EXT_WORD;
      bus.wdata_M    = 32'h0;
   endtask

   // One MEM-stage instruction per cycle; returns just after the capturing edge.
   task automatic op(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input logic rd, input logic [1:0] ext);
      bus.PC_M       = pc;
      bus.addr_M     = addr;
      bus.wdata_M    = wdata;
      bus.ByteEn     = be;
      bus.mem_read_M = rd;
      bus.Load_extOp = ext;
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic sw(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] be);
      op(32'h1000, addr, d, be, 1'b0, EXT_WORD);
   endtask

   task automatic ld(input logic [31:0] addr, input logic [1:0] ext);
      op(32'h2000, addr, 32'h0, 4'h0, 1'b1, ext);
   endtask

   initial begin
      bus.PC_M   = 32'h0;
      bus.addr_M = 32'h0;
      idle();
      #2 reset = 1'b0;
      #1 check_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      cmp("reset rdata_W",  bus.rdata_W, 32'h0);
      cmp("reset rvalid_W", {31'h0, bus.rvalid_W}, 32'h0);
      cmp("reset bad_be_W", {31'h0, bus.bad_be_W}, 32'h0);
      reset = 1'b1;

      sw(32'h10, 32'h1234_5678, 4'b1111);
      ld(32'h10, EXT_WORD);
      cmp("lw 0x10 before reset", bus.rdata_W, 32'h1234_5678);

      // Asynchronous reset in the middle of a cycle while a load is presented.
      bus.addr_M     = 32'h10;
      bus.mem_read_M = 1'b1;
      #3 reset = 1'b0;
      @(posedge clk);
      #1;
      cmp("rdata_W in reset",  bus.rdata_W, 32'h0);
      cmp("rvalid_W in reset", {31'h0, bus.rvalid_W}, 32'h0);
      #2 reset = 1'b1;
      ld(32'h10, EXT_WORD);
      cmp("lw 0x10 after reset", bus.rdata_W, 32'h0);

      sw(32'h20, 32'hDEAD_BEEF, 4'b1111);
      sw(32'h22, 32'h0000_00AA, 4'b0100);
      ld(32'h20, EXT_WORD);
      cmp("sw+sb merge", bus.rdata_W, 32'hDEAA_BEEF);
      cmp("rvalid_W on load", {31'h0, bus.rvalid_W}, 32'h1);
      ld(32'h23, EXT_WORD);
      cmp("lw ignores low bits", bus.rdata_W, 32'hDEAA_BEEF);

      sw(32'h30, 32'h80FF_7F01, 4'b1111);
      ld(32'h31, EXT_BYTE);
      cmp("lb 0x31", bus.rdata_W, 32'h0000_007F);
      ld(32'h32, EXT_BYTE);
      cmp("lb 0x32", bus.rdata_W, 32'hFFFF_FFFF);
      ld(32'h32, EXT_HALF);
      cmp("lh 0x32", bus.rdata_W, 32'hFFFF_80FF);
      ld(32'h30, EXT_HALF);
      cmp("lh 0x30", bus.rdata_W, 32'h0000_7F01);
      ld(32'h30, 2'b11);
      cmp("reserved ext as word", bus.rdata_W, 32'h80FF_7F01);

      sw(32'h40, 32'hFFFF_FFFF, 4'b0101);
      cmp("bad_be illegal BE", {31'h0, bus.bad_be_W}, 32'h1);
      ld(32'h40, EXT_WORD);
      cmp("illegal BE no write", bus.rdata_W, 32'h0);
      cmp("bad_be clears", {31'h0, bus.bad_be_W}, 32'h0);

      sw(32'h3FFC, 32'hCAFE_F00D, 4'b1111);
      cmp("last word in range", {31'h0, bus.bad_be_W}, 32'h0);
      ld(32'h3FFC, EXT_WORD);
      cmp("lw last word", bus.rdata_W, 32'hCAFE_F00D);
      sw(BASE + 32'(4 * DEPTH), 32'h5555_5555, 4'b1111);
      cmp("bad_be out of range", {31'h0, bus.bad_be_W}, 32'h1);
      ld(BASE + 32'(4 * DEPTH), EXT_WORD);
      cmp("lw out of range", bus.rdata_W, 32'h0);
      cmp("rvalid out of range", {31'h0, bus.rvalid_W}, 32'h1);

      sw(32'h50, 32'h1111_1111, 4'b1111);
      op(32'h1100, 32'h50, 32'h2222_2222, 4'b1111, 1'b1, EXT_WORD);
      cmp("read+write old data", bus.rdata_W, 32'h1111_1111);
      ld(32'h50, EXT_WORD);
      cmp("read after write", bus.rdata_W, 32'h2222_2222);

      op(32'h3004, 32'h62, 32'h0000_BEEF, 4'b1100, 1'b0, EXT_WORD);
      ld(32'h60, EXT_WORD);
      cmp("sh 0x62", bus.rdata_W, 32'hBEEF_0000);
      op(32'h3008, 32'h60, 32'h1234_5678, 4'b0110, 1'b0, EXT_WORD);
      cmp("bad_be 0110", {31'h0, bus.bad_be_W}, 32'h1);
      ld(32'h62, EXT_HALF);
      cmp("lh 0x62 after reject", bus.rdata_W, 32'hFFFF_BEEF);

      sw(32'h70, 32'h0000_0034, 4'b0001);
      sw(32'h70, 32'h0000_0056, 4'b1000);
      sw(32'h70, 32'h0000_9ABC, 4'b0011);
      ld(32'h70, EXT_WORD);
      cmp("byte/half lanes", bus.rdata_W, 32'h5600_9ABC);

      repeat (2) @(posedge clk);
      #1;
      check_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
